// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and hazard_ctrl: ID-stage fields in,
// stall/flush/forward controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              valid_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              rs1_used_ID;
  logic              rs2_used_ID;
  logic [REG_AW-1:0] rd_ID;
  logic              RegWrite_ID;
  logic              MemRead_ID;
  logic              branch_taken_EX;
  logic              PC_en;
  logic              en_IFID;
  logic              NOP_IFID;
  logic              NOP_IDEX;
  logic [1:0]        fwdA_EX;
  logic [1:0]        fwdB_EX;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
           rd_ID, RegWrite_ID, MemRead_ID, branch_taken_EX,
    input  PC_en, en_IFID, NOP_IFID, NOP_IDEX, fwdA_EX, fwdB_EX,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_ID, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
           rd_ID, RegWrite_ID, MemRead_ID, branch_taken_EX,
    output PC_en, en_IFID, NOP_IFID, NOP_IDEX, fwdA_EX, fwdB_EX,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use/branch hazard and EX forwarding controller for the 5-stage pipeline.
// HZD_FORWARD_EN enables forwarding; without it every RAW against EX/MEM stalls.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_HZD,
  input  logic          rst_HZD,
  hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_AW-1:0] rd_EX, rs1_EX, rs2_EX, rd_MEM, rd_WB;
  logic              RegWrite_EX, MemRead_EX, RegWrite_MEM, RegWrite_WB;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              raw_ex, raw_mem, stall, flush;

  function automatic logic src_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                   input logic used, input logic [REG_AW-1:0] rs);
    return wr && (rd != '0) && used && (rs == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic wr_m, input logic [REG_AW-1:0] rd_m,
                                         input logic wr_w, input logic [REG_AW-1:0] rd_w);
    if (src_hit(wr_m, rd_m, 1'b1, rs))      return 2'b01;
    else if (src_hit(wr_w, rd_w, 1'b1, rs)) return 2'b10;
    else                                    return 2'b00;
  endfunction

  assign raw_ex  = hz.valid_ID &&
                   (src_hit(RegWrite_EX, rd_EX, hz.rs1_used_ID, hz.rs1_ID) ||
                    src_hit(RegWrite_EX, rd_EX, hz.rs2_used_ID, hz.rs2_ID));
  assign raw_mem = hz.valid_ID &&
                   (src_hit(RegWrite_MEM, rd_MEM, hz.rs1_used_ID, hz.rs1_ID) ||
                    src_hit(RegWrite_MEM, rd_MEM, hz.rs2_used_ID, hz.rs2_ID));
  assign flush   = hz.branch_taken_EX;

`ifdef HZD_FORWARD_EN
  assign stall = raw_ex && MemRead_EX;
`else
  // Without forwarding a producer must reach WB; regfile writes before reads.
  assign stall = raw_ex || raw_mem;
`endif

  always_comb begin
    hz.PC_en    = 1'b1;
    hz.en_IFID  = 1'b1;
    hz.NOP_IFID = 1'b0;
    hz.NOP_IDEX = 1'b0;
    hz.fwdA_EX  = 2'b00;
    hz.fwdB_EX  = 2'b00;
    if (!rst_HZD) begin
      if (flush) begin
        hz.NOP_IFID = 1'b1;
        hz.NOP_IDEX = 1'b1;
      end else if (stall) begin
        hz.PC_en    = 1'b0;
        hz.en_IFID  = 1'b0;
        hz.NOP_IDEX = 1'b1;
      end
`ifdef HZD_FORWARD_EN
      hz.fwdA_EX = fwd_sel(rs1_EX, RegWrite_MEM, rd_MEM, RegWrite_WB, rd_WB);
      hz.fwdB_EX = fwd_sel(rs2_EX, RegWrite_MEM, rd_MEM, RegWrite_WB, rd_WB);
`endif
    end
  end

  always_ff @(posedge clk_HZD) begin
    if (rst_HZD) begin
      rd_EX        <= '0;
      rs1_EX       <= '0;
      rs2_EX       <= '0;
      RegWrite_EX  <= 1'b0;
      MemRead_EX   <= 1'b0;
      rd_MEM       <= '0;
      RegWrite_MEM <= 1'b0;
      rd_WB        <= '0;
      RegWrite_WB  <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      rd_WB        <= rd_MEM;
      RegWrite_WB  <= RegWrite_MEM;
      rd_MEM       <= rd_EX;
      RegWrite_MEM <= RegWrite_EX;
      if (hz.NOP_IDEX || !hz.valid_ID) begin
        rd_EX       <= '0;
        rs1_EX      <= '0;
        rs2_EX      <= '0;
        RegWrite_EX <= 1'b0;
        MemRead_EX  <= 1'b0;
      end else begin
        rd_EX       <= hz.rd_ID;
        rs1_EX      <= hz.rs1_used_ID ? hz.rs1_ID : '0;
        rs2_EX      <= hz.rs2_used_ID ? hz.rs2_ID : '0;
        RegWrite_EX <= hz.RegWrite_ID;
        MemRead_EX  <= hz.MemRead_ID;
      end
      // A flush masks any coincident load-use, so only one counter moves.
      if (flush) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end else if (stall) begin
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W=4): pipeline-occupancy model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = 15;
`ifdef HZD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();
  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.clk_HZD(clk), .rst_HZD(rst), .hz(hz));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: what occupies EX (0), MEM (1), WB (2), as instructions in flight.
  typedef struct packed {
    logic          wr;
    logic          ld;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } ins_t;

  ins_t pipe [3];
  int   m_stall = 0;
  int   m_flush = 0;
  bit   armed   = 1'b0;

  function automatic bit writes_to(input ins_t p, input logic [AW-1:0] r);
    return p.wr && p.rd != 0 && p.rd == r;
  endfunction

  function automatic bit needs(input ins_t p);
    return hz.valid_ID && ((hz.rs1_used_ID && writes_to(p, hz.rs1_ID)) ||
                           (hz.rs2_used_ID && writes_to(p, hz.rs2_ID)));
  endfunction

  function automatic bit m_hazard();
    if (FWD) return needs(pipe[0]) && pipe[0].ld;
    else     return needs(pipe[0]) || needs(pipe[1]);
  endfunction

  function automatic int m_fwd(input logic [AW-1:0] r);
    if (!FWD)                   return 0;
    if (writes_to(pipe[1], r))  return 1;
    if (writes_to(pipe[2], r))  return 2;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_stall = 0;
      m_flush = 0;
      armed   = 1'b1;
    end else begin
      bit fl, st;
      fl = hz.branch_taken_EX;
      st = !fl && m_hazard();
      if (fl && m_flush < CMAX) m_flush++;
      if (st && m_stall < CMAX) m_stall++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || st || !hz.valid_ID) pipe[0] = '0;
      else pipe[0] = '{wr: hz.RegWrite_ID, ld: hz.MemRead_ID, rd: hz.rd_ID,
                       rs1: hz.rs1_used_ID ? hz.rs1_ID : '0,
                       rs2: hz.rs2_used_ID ? hz.rs2_ID : '0};
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      bit fl, st;
      fl = !rst && hz.branch_taken_EX;
      st = !rst && !fl && m_hazard();
      check("PC_en",     int'(hz.PC_en),    int'(!st));
      check("en_IFID",   int'(hz.en_IFID),  int'(!st));
      check("NOP_IFID",  int'(hz.NOP_IFID), int'(fl));
      check("NOP_IDEX",  int'(hz.NOP_IDEX), int'(fl || st));
      check("fwdA_EX",   int'(hz.fwdA_EX),  rst ? 0 : m_fwd(pipe[0].rs1));
      check("fwdB_EX",   int'(hz.fwdB_EX),  rst ? 0 : m_fwd(pipe[0].rs2));
      check("stall_cnt", int'(hz.stall_cnt), m_stall);
      check("flush_cnt", int'(hz.flush_cnt), m_flush);
    end
  end

  task automatic drive(input logic r, input logic v,
                       input logic [AW-1:0] s1, input logic u1,
                       input logic [AW-1:0] s2, input logic u2,
                       input logic [AW-1:0] d, input logic w, input logic l,
                       input logic b);
    @(posedge clk);
    #1;
    rst = r;
    hz.valid_ID = v;       hz.rs1_ID = s1;      hz.rs1_used_ID = u1;
    hz.rs2_ID = s2;        hz.rs2_used_ID = u2; hz.rd_ID = d;
    hz.RegWrite_ID = w;    hz.MemRead_ID = l;   hz.branch_taken_EX = b;
    @(negedge clk);
  endtask

  task automatic nop();                          drive(0,0, 0,0, 0,0, 0,0,0, 0); endtask
  task automatic load(input logic [AW-1:0] d);   drive(0,1, 0,0, 0,0, d,1,1, 0); endtask
  task automatic alu(input logic [AW-1:0] d);    drive(0,1, 0,0, 0,0, d,1,0, 0); endtask
  task automatic use1(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic b = 0);
    drive(0,1, s,1, 0,0, d,1,0, b);
  endtask
  task automatic use2(input logic [AW-1:0] s, input logic [AW-1:0] d);
    drive(0,1, 0,0, s,1, d,1,0, 0);
  endtask
  task automatic drain(); repeat (3) nop(); endtask

  initial begin
    hz.valid_ID = 0; hz.rs1_ID = 0; hz.rs2_ID = 0; hz.rs1_used_ID = 0;
    hz.rs2_used_ID = 0; hz.rd_ID = 0; hz.RegWrite_ID = 0; hz.MemRead_ID = 0;
    hz.branch_taken_EX = 0;

    drive(1,0, 0,0, 0,0, 0,0,0, 0);
    drive(1,1, 5,1, 5,1, 5,1,1, 1);
    check("lit_rst_pc",  int'(hz.PC_en), 1);
    check("lit_rst_nop", int'(hz.NOP_IFID), 0);
    nop();
    check("lit_idle_pc",    int'(hz.PC_en), 1);
    check("lit_idle_idex",  int'(hz.NOP_IDEX), 0);
    check("lit_idle_stall", int'(hz.stall_cnt), 0);
    check("lit_idle_flush", int'(hz.flush_cnt), 0);

    // load x5 -> consumer on rs1
    load(5);
    use1(5, 6);
    check("lit_lu_pc",   int'(hz.PC_en), 0);
    check("lit_lu_en",   int'(hz.en_IFID), 0);
    check("lit_lu_idex", int'(hz.NOP_IDEX), 1);
    use1(5, 6);
    check("lit_lu_2nd_pc", int'(hz.PC_en), FWD ? 1 : 0);
    if (!FWD) use1(5, 6);
    check("lit_lu_release", int'(hz.PC_en), 1);
    nop();
    check("lit_lu_fwdA",  int'(hz.fwdA_EX), FWD ? 2 : 0);
    check("lit_lu_stall", int'(hz.stall_cnt), FWD ? 1 : 2);

    // ALU x7 -> immediate consumer on rs2
    drain();
    alu(7);
    use2(7, 8);
    check("lit_alu_pc", int'(hz.PC_en), FWD ? 1 : 0);
    if (!FWD) begin
      use2(7, 8);
      check("lit_alu_pc2", int'(hz.PC_en), 0);
      use2(7, 8);
      check("lit_alu_pc3", int'(hz.PC_en), 1);
    end
    nop();
    check("lit_alu_fwdB", int'(hz.fwdB_EX), FWD ? 1 : 0);

    // consumer two instructions after the producer
    drain();
    alu(7);
    alu(9);
    use2(7, 10);
    check("lit_far_pc", int'(hz.PC_en), FWD ? 1 : 0);
    if (!FWD) use2(7, 10);
    nop();
    check("lit_far_fwdB", int'(hz.fwdB_EX), FWD ? 2 : 0);

    // branch in the same cycle as a load-use
    drain();
    load(5);
    use1(5, 6, 1'b1);
    check("lit_fl_nopif", int'(hz.NOP_IFID), 1);
    check("lit_fl_idex",  int'(hz.NOP_IDEX), 1);
    check("lit_fl_pc",    int'(hz.PC_en), 1);
    nop();
    check("lit_fl_stall", int'(hz.stall_cnt), FWD ? 1 : 5);
    check("lit_fl_flush", int'(hz.flush_cnt), 1);

    // x0 never stalls or forwards
    drain();
    load(0);
    use1(0, 11);
    check("lit_x0_pc", int'(hz.PC_en), 1);
    nop();
    check("lit_x0_fwdA", int'(hz.fwdA_EX), 0);

    // saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      load(5);
      use1(5, 6);
      nop();
      nop();
    end
    check("lit_sat_stall", int'(hz.stall_cnt), CMAX);

    // reset in the middle of a stall
    load(5);
    use1(5, 6);
    check("lit_mid_pc", int'(hz.PC_en), 0);
    drive(1,1, 5,1, 0,0, 6,1,0, 0);
    check("lit_mid_rst_pc",   int'(hz.PC_en), 1);
    check("lit_mid_rst_idex", int'(hz.NOP_IDEX), 0);
    use1(5, 6);
    check("lit_mid_after_pc", int'(hz.PC_en), 1);
    check("lit_mid_after_sc", int'(hz.stall_cnt), 0);
    nop();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Drives the stall/flush controls consumed by the PC register, the IF/ID register (en_IFID, NOP_IFID) and the ID/EX register.
- Keeps a shadow copy of the destination/source fields for EX, MEM and WB.
- Detects load-use and branch hazards and generates EX-stage forwarding selects.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- clk_HZD  in  1  clock; all state updates on posedge.
- rst_HZD  in  1  synchronous, active-high reset.
- valid_ID  in  1  ID-stage instruction valid, driven by valid_IFID.
- rs1_ID  in  REG_AW  ID source register 1.
- rs2_ID  in  REG_AW  ID source register 2.
- rs1_used_ID  in  1  instruction reads rs1.
- rs2_used_ID  in  1  instruction reads rs2.
- rd_ID  in  REG_AW  ID destination register.
- RegWrite_ID  in  1  ID instruction writes rd.
- MemRead_ID  in  1  ID instruction is a load.
- branch_taken_EX  in  1  branch/jump in EX redirects PC this cycle.
- PC_en  out  1  PC write enable.
- en_IFID  out  1  IF/ID enable (0 = hold).
- NOP_IFID  out  1  IF/ID NOP insert.
- NOP_IDEX  out  1  ID/EX bubble insert.
- fwdA_EX  out  2  rs1 operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwdB_EX  out  2  rs2 operand select, same encoding.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  flush cycles.

Behaviour:
- Shadow state, one bundle per stage:
  - EX: rd, RegWrite, MemRead, rs1, rs2.
  - MEM: rd, RegWrite.
  - WB: rd, RegWrite.
- rst_HZD=1 at a clock edge clears all shadow state and both counters to 0.
- While rst_HZD=1, outputs are forced to PC_en=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0, fwdA_EX=fwdB_EX=00.
- Reset asserted mid-stall or mid-flush aborts it: the next non-reset cycle evaluates from cleared shadows.
- Control outputs are combinational from shadows plus ID inputs, so hazards act in the same cycle with zero latency.
- load_use = valid_ID & MemRead_EX & RegWrite_EX & (rd_EX!=0) & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- Priority: flush over stall over normal.
  - Flush (branch_taken_EX=1): PC_en=1, en_IFID=1, NOP_IFID=1, NOP_IDEX=1. load_use is ignored.
  - Stall (load_use=1): PC_en=0, en_IFID=0, NOP_IFID=0, NOP_IDEX=1.
  - Normal: PC_en=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0.
- Shadow advance every non-reset cycle: WB<=MEM, MEM<=EX.
  - EX receives a bubble (all fields 0) when NOP_IDEX=1 or valid_ID=0.
  - Otherwise EX<=ID fields. rs1/rs2 are captured as 0 when the corresponding *_used_ID=0.
- Forwarding for each of A (rs1_EX) and B (rs2_EX):
  - 01 if RegWrite_MEM & rd_MEM!=0 & rd_MEM==rs.
  - Else 10 if RegWrite_WB & rd_WB!=0 & rd_WB==rs.
  - Else 00. MEM has priority over WB.
- Register x0 never causes a stall or a forward.
- Counters increment by 1 per cycle of stall (stall_cnt) or flush (flush_cnt), saturating at all-ones with no wrap.
- A simultaneous flush and load_use counts as flush only.

Optional Feature:
- Macro: HZD_FORWARD_EN.
- Defined: forwarding active as above; only load-use stalls, for exactly 1 cycle.
- Undefined:
  - fwdA_EX and fwdB_EX tied to 00.
  - Stall condition becomes any RAW against EX or MEM (RegWrite, rd!=0, used source matches). Loads and non-loads are treated alike.
  - A dependence on EX stalls 2 cycles; a dependence on MEM stalls 1. The regfile is write-before-read, so WB needs no stall.
  - stall_cnt counts every such stall cycle.

Test Plan:
- Reset held for 2 cycles, then released with valid_ID=0 → PC_en=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0, fwd=00, both counters 0.
- Load x5 in ID, next cycle a consumer reading rs1=x5 → exactly 1 cycle with PC_en=0, en_IFID=0, NOP_IDEX=1; the following cycle fwdA_EX=10; stall_cnt=1.
- ALU op writing x7, then op reading rs2=x7 → no stall, fwdB_EX=01. Consumer two instructions later → fwdB_EX=10.
- branch_taken_EX=1 in the same cycle as a load_use condition → NOP_IFID=1, NOP_IDEX=1, PC_en=1; flush_cnt+1, stall_cnt unchanged.
- Load to x0 followed by a consumer reading x0 → no stall, fwd=00.
- Force stall_cnt near saturation (CNT_W=4 build), apply 20 load-use stalls → stall_cnt holds 4'hF. Without HZD_FORWARD_EN, ALU→dependent back-to-back → 2 stall cycles.
